dm_trace_mem: RTL

//  Data memory for the pipelined MIPS core, directly downstream of the core's M-stage data port.

---
 rtl/dm_trace_mem.sv | 108 ++++++++++
 1 files changed

// File: rtl/dm_trace_mem.sv
// Data memory for the pipelined core's M stage, with a combinational read port.
// Every committed store is also logged to a small trace FIFO that drains over valid/ready.
module dm_trace_mem #(
   parameter int DEPTH_WORDS = 4096,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m_data_addr,
   input  logic [31:0] m_data_wdata,
   input  logic [3:0]  m_data_byteen,
   input  logic [31:0] m_inst_addr,
   output logic [31:0] m_data_rdata,
   output logic        trace_valid,
   input  logic        trace_ready,
   output logic [31:0] trace_pc,
   output logic [31:0] trace_addr,
   output logic [31:0] trace_data,
   output logic        trace_overflow
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [31:0]   mem_q [DEPTH_WORDS];
   logic [AW-1:0] idx;
   logic          in_range;
   logic          wr_en;
   logic [31:0]   old_word;
   logic [31:0]   merged_word;
   logic          unused_addr_lsbs;

   assign idx              = m_data_addr[AW+1:2];
   assign in_range         = (m_data_addr[31:AW+2] == '0);
   assign wr_en            = in_range && (m_data_byteen != 4'b0000);
   assign unused_addr_lsbs = ^m_data_addr[1:0];

   always_comb begin
      old_word    = mem_q[idx];
      merged_word = old_word;
      for (int i = 0; i < 4; i++) begin
         if (m_data_byteen[i]) merged_word[8*i +: 8] = m_data_wdata[8*i +: 8];
      end
   end

   // Read shows the pre-write word; the store lands on the edge.
   assign m_data_rdata = in_range ? old_word : 32'h0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[idx] <= merged_word;
      end
   end

   logic [31:0] fifo_pc_q   [FIFO_DEPTH];
   logic [31:0] fifo_addr_q [FIFO_DEPTH];
   logic [31:0] fifo_data_q [FIFO_DEPTH];
   logic [PW:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0] rd_ptr_q, rd_ptr_d;
   logic        ovf_q, ovf_d;
   logic        empty, full, pop, push;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign pop   = !empty && trace_ready;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign push  = wr_en && (!full || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !push) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_pc_q[i]   <= '0;
            fifo_addr_q[i] <= '0;
            fifo_data_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         if (push) begin
            fifo_pc_q[wr_ptr_q[PW-1:0]]   <= m_inst_addr;
            fifo_addr_q[wr_ptr_q[PW-1:0]] <= {m_data_addr[31:2], 2'b00};
            fifo_data_q[wr_ptr_q[PW-1:0]] <= merged_word;
         end
      end
   end

   assign trace_valid    = !empty;
   assign trace_pc       = fifo_pc_q[rd_ptr_q[PW-1:0]];
   assign trace_addr     = fifo_addr_q[rd_ptr_q[PW-1:0]];
   assign trace_data     = fifo_data_q[rd_ptr_q[PW-1:0]];
   assign trace_overflow = ovf_q;

endmodule
